// File: rtl/cajero_pkg.sv
// Shared encodings for the parametrised ATM controller: FSM states and
// transaction-type codes.
package cajero_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PIN      = 3'd1,
        VERIFICA = 3'd2,
        TRANS    = 3'd3,
        DEPOSITO = 3'd4,
        RETIRO   = 3'd5,
        BLOQUEO  = 3'd6
    } estado_t;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_pin_check.sv
// PIN entry datapath: digit shift register, digit counter, PIN compare,
// wrong-attempt counter and the registered last-attempt warning.
module cajero_pin_check #(
    parameter int PIN_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int MAX_INTENTOS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          iniciar,
    input  logic                          captura,
    input  logic                          verificar,
    input  logic                          pin_next,
    input  logic [DIGIT_W-1:0]            digito,
    input  logic [PIN_DIGITS*DIGIT_W-1:0] pin_correcto,
    output logic                          done,
    output logic                          match,
    output logic                          agotado,
    output logic                          advertencia
);

    localparam int PIN_W = PIN_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int INT_W = $clog2(MAX_INTENTOS + 1);

    logic [PIN_W-1:0] pin_q;
    logic [CNT_W-1:0] cnt_q;
    logic [INT_W-1:0] intentos_q;
    logic [INT_W-1:0] intentos_d;

    assign done    = captura && (cnt_q == CNT_W'(PIN_DIGITS - 1));
    assign match   = (pin_q == pin_correcto);
    // The failure being evaluated now is the last one allowed.
    assign agotado = (intentos_q == INT_W'(MAX_INTENTOS - 1));

    always_comb begin
        intentos_d = intentos_q;
        if (iniciar) begin
            intentos_d = '0;
        end else if (verificar) begin
            intentos_d = match ? '0 : intentos_q + INT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_q       <= '0;
            cnt_q       <= '0;
            intentos_q  <= '0;
            advertencia <= 1'b0;
        end else begin
            if (iniciar) begin
                pin_q <= '0;
                cnt_q <= '0;
            end else if (captura) begin
                pin_q <= (pin_q << DIGIT_W) | PIN_W'(digito);
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (verificar) begin
                cnt_q <= '0;
            end
            intentos_q  <= intentos_d;
            advertencia <= (MAX_INTENTOS > 1) && pin_next &&
                           (intentos_d == INT_W'(MAX_INTENTOS - 1));
        end
    end

endmodule

// File: rtl/cajero_automatico_param.sv
// ATM session controller: card, PIN with retries, one deposit/withdrawal.
// Optional inactivity timeout in PIN/TRANS is built when TIMEOUT_EN is defined.
module cajero_automatico_param
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int MAX_INTENTOS = 3,
    parameter int MONTO_W      = 32,
    parameter int SALDO_W      = 64,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tarjeta_recibida,
    input  logic [PIN_DIGITS*DIGIT_W-1:0] pin_correcto,
    input  logic [DIGIT_W-1:0]            digito,
    input  logic                          digito_stb,
    input  logic                          tipo_trans,
    input  logic [MONTO_W-1:0]            monto,
    input  logic                          monto_stb,
    input  logic [SALDO_W-1:0]            saldo_in,
    output logic [SALDO_W-1:0]            saldo_out,
    output logic                          balance_actualizado,
    output logic                          entregar_dinero,
    output logic                          fondos_insuficientes,
    output logic                          pin_incorrecto,
    output logic                          advertencia,
    output logic                          bloqueo,
    output logic                          fin,
    output logic [2:0]                    estado
);

    // state    | meaning
    // IDLE     | waiting for a card; saldo_out holds last session result
    // PIN      | collecting PIN digits
    // VERIFICA | one-cycle PIN compare and attempt bookkeeping
    // TRANS    | waiting for amount and transaction type
    // DEPOSITO | one-cycle saturating add
    // RETIRO   | one-cycle funds check and subtract
    // BLOQUEO  | card blocked, terminal until reset

    estado_t              state_q, state_d;
    logic [MONTO_W-1:0]   monto_q;
    logic [SALDO_W-1:0]   saldo_d;
    logic [SALDO_W:0]     suma;
    logic                 fondos_ok;
    logic                 bal_d, entregar_d, fondos_d, pin_inc_d, fin_d;
    logic                 iniciar, captura, verificar, trans_stb;
    logic                 done, match, agotado, timeout;

    assign iniciar   = (state_q == IDLE) && tarjeta_recibida;
    assign captura   = (state_q == PIN) && digito_stb;
    assign verificar = (state_q == VERIFICA);
    assign trans_stb = (state_q == TRANS) && monto_stb;

    assign suma      = {1'b0, saldo_q_ext()} + (SALDO_W + 1)'(monto_q);
    assign fondos_ok = SALDO_W'(monto_q) <= saldo_out;

    function automatic logic [SALDO_W-1:0] saldo_q_ext();
        return saldo_out;
    endfunction

    cajero_pin_check #(
        .PIN_DIGITS   (PIN_DIGITS),
        .DIGIT_W      (DIGIT_W),
        .MAX_INTENTOS (MAX_INTENTOS)
    ) u_pin_check (
        .clk          (clk),
        .reset        (reset),
        .iniciar      (iniciar),
        .captura      (captura),
        .verificar    (verificar),
        .pin_next     (state_d == PIN),
        .digito       (digito),
        .pin_correcto (pin_correcto),
        .done         (done),
        .match        (match),
        .agotado      (agotado),
        .advertencia  (advertencia)
    );

`ifdef TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_q;
    logic             espera;

    // Down-counter reloads on any legal strobe or outside PIN/TRANS.
    assign espera  = ((state_q == PIN) && !digito_stb) ||
                     ((state_q == TRANS) && !monto_stb);
    assign timeout = espera && (tmo_q == '0);

    always_ff @(posedge clk) begin
        if (reset || !espera) begin
            tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - TMO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= IDLE;
            saldo_out            <= '0;
            monto_q              <= '0;
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            pin_incorrecto       <= 1'b0;
            bloqueo              <= 1'b0;
            fin                  <= 1'b0;
        end else begin
            state_q              <= state_d;
            saldo_out            <= saldo_d;
            if (trans_stb) begin
                monto_q <= monto;
            end
            balance_actualizado  <= bal_d;
            entregar_dinero      <= entregar_d;
            fondos_insuficientes <= fondos_d;
            pin_incorrecto       <= pin_inc_d;
            bloqueo              <= (state_d == BLOQUEO);
            fin                  <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (tarjeta_recibida) state_d = PIN;
            PIN: begin
                if (timeout)   state_d = IDLE;
                else if (done) state_d = VERIFICA;
            end
            VERIFICA: begin
                if (match)        state_d = TRANS;
                else if (agotado) state_d = BLOQUEO;
                else              state_d = PIN;
            end
            TRANS: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (monto_stb) begin
                    state_d = (tipo_trans == TIPO_RETIRO) ? RETIRO : DEPOSITO;
                end
            end
            DEPOSITO: state_d = IDLE;
            RETIRO:   state_d = IDLE;
            BLOQUEO:  state_d = BLOQUEO;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        saldo_d    = saldo_out;
        bal_d      = 1'b0;
        entregar_d = 1'b0;
        fondos_d   = 1'b0;
        pin_inc_d  = 1'b0;
        fin_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tarjeta_recibida) saldo_d = saldo_in;
            end
            PIN, TRANS: begin
                if (timeout) fin_d = 1'b1;
            end
            VERIFICA: begin
                if (!match) begin
                    pin_inc_d = 1'b1;
                    fin_d     = agotado;
                end
            end
            DEPOSITO: begin
                saldo_d = suma[SALDO_W] ? '1 : suma[SALDO_W-1:0];
                bal_d   = 1'b1;
                fin_d   = 1'b1;
            end
            RETIRO: begin
                fin_d = 1'b1;
                if (fondos_ok) begin
                    saldo_d    = saldo_out - SALDO_W'(monto_q);
                    entregar_d = 1'b1;
                    bal_d      = 1'b1;
                end else begin
                    fondos_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign estado = state_q;

endmodule

// File: tb/tb_cajero_automatico_param.sv
// Directed bench for cajero_automatico_param with hand-computed expectations.
module tb_cajero_automatico_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        tarjeta_recibida;
    logic [15:0] pin_correcto;
    logic [3:0]  digito;
    logic        digito_stb;
    logic        tipo_trans;
    logic [31:0] monto;
    logic        monto_stb;
    logic [63:0] saldo_in;
    logic [63:0] saldo_out;
    logic        balance_actualizado, entregar_dinero, fondos_insuficientes;
    logic        pin_incorrecto, advertencia, bloqueo, fin;
    logic [2:0]  estado;

    int n_checks = 0;
    int n_errors = 0;
    int n_pin_inc = 0;
    int n_fin = 0;

    always #5 clk = ~clk;

    cajero_automatico_param #(
        .PIN_DIGITS   (4),
        .DIGIT_W      (4),
        .MAX_INTENTOS (3),
        .MONTO_W      (32),
        .SALDO_W      (64),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .pin_correcto         (pin_correcto),
        .digito               (digito),
        .digito_stb           (digito_stb),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .saldo_in             (saldo_in),
        .saldo_out            (saldo_out),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo),
        .fin                  (fin),
        .estado               (estado)
    );

    always @(negedge clk) begin
        if (pin_incorrecto) n_pin_inc++;
        if (fin)            n_fin++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_card();
        tarjeta_recibida = 1'b1;
        tick();
        tarjeta_recibida = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        digito     = d;
        digito_stb = 1'b1;
        tick();
        digito_stb = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        key(p[15:12]);
        key(p[11:8]);
        key(p[7:4]);
        key(p[3:0]);
    endtask

    // Leaves the bench one cycle after the DEPOSITO/RETIRO edge, where results show.
    task automatic do_trans(input logic t, input logic [31:0] m);
        tipo_trans = t;
        monto      = m;
        monto_stb  = 1'b1;
        tick();
        monto_stb  = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        tarjeta_recibida = 1'b0;
        pin_correcto = 16'h1234;
        digito = 4'd0;
        digito_stb = 1'b0;
        tipo_trans = 1'b0;
        monto = 32'd0;
        monto_stb = 1'b0;
        saldo_in = 64'd1000;

        repeat (3) tick();
        check_val("rst_estado", estado, 0);
        check_val("rst_fin", fin, 0);
        check_val("rst_saldo", saldo_out, 0);
        check_val("rst_pulses", {balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto}, 0);
        check_val("rst_levels", {advertencia, bloqueo}, 0);
        reset = 1'b0;
        tick();

        // Deposit 500
        insert_card();
        check_val("card_estado", estado, 1);
        check_val("card_saldo", saldo_out, 1000);
        monto_stb = 1'b1;
        tick();
        monto_stb = 1'b0;
        check_val("pin_ignores_monto", estado, 1);
        enter_pin(16'h1234);
        check_val("verifica_estado", estado, 2);
        tick();
        check_val("trans_estado", estado, 3);
        do_trans(1'b0, 32'd500);
        check_val("dep_bal", balance_actualizado, 1);
        check_val("dep_fin", fin, 1);
        check_val("dep_saldo", saldo_out, 1500);
        check_val("dep_estado", estado, 0);
        tick();
        check_val("dep_pulse_len", {balance_actualizado, fin}, 0);
        check_val("idle_hold_saldo", saldo_out, 1500);

        // Withdraw 1500 from reloaded 1000: rejected
        insert_card();
        check_val("reload_saldo", saldo_out, 1000);
        enter_pin(16'h1234);
        tick();
        do_trans(1'b1, 32'd1500);
        check_val("nsf_fondos", fondos_insuficientes, 1);
        check_val("nsf_fin", fin, 1);
        check_val("nsf_no_entregar", {entregar_dinero, balance_actualizado}, 0);
        check_val("nsf_saldo", saldo_out, 1000);
        tick();

        // Withdraw 400; stray digit in TRANS ignored
        insert_card();
        enter_pin(16'h1234);
        tick();
        key(4'd5);
        check_val("trans_ignores_digit", estado, 3);
        do_trans(1'b1, 32'd400);
        check_val("wd_entregar", {entregar_dinero, balance_actualizado, fin}, 3'b111);
        check_val("wd_saldo", saldo_out, 600);
        tick();

        // One wrong PIN, then correct; withdraw full balance (boundary)
        n_pin_inc = 0;
        insert_card();
        enter_pin(16'h1111);
        tick();
        check_val("retry_estado", estado, 1);
        check_val("retry_pin_inc", pin_incorrecto, 1);
        check_val("retry_adv", advertencia, 0);
        enter_pin(16'h1234);
        tick();
        check_val("retry_trans", estado, 3);
        do_trans(1'b1, 32'd1000);
        check_val("exact_entregar", entregar_dinero, 1);
        check_val("exact_saldo", saldo_out, 0);
        check_val("retry_pin_inc_count", n_pin_inc, 1);
        tick();

        // Three wrong PINs -> block
        n_pin_inc = 0;
        n_fin = 0;
        insert_card();
        enter_pin(16'h1111);
        tick();
        check_val("blk_adv_1", advertencia, 0);
        enter_pin(16'h1111);
        tick();
        check_val("blk_adv_2", advertencia, 1);
        enter_pin(16'h1111);
        tick();
        check_val("blk_estado", estado, 6);
        check_val("blk_bloqueo", bloqueo, 1);
        check_val("blk_fin", fin, 1);
        check_val("blk_adv_3", advertencia, 0);
        repeat (4) tick();
        check_val("blk_pin_inc_count", n_pin_inc, 3);
        check_val("blk_fin_count", n_fin, 1);
        insert_card();
        tick();
        check_val("blk_ignores_card", estado, 6);
        check_val("blk_saldo", saldo_out, 1000);

        // Reset out of BLOQUEO
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_mid_estado", estado, 0);
        check_val("rst_mid_bloqueo", bloqueo, 0);
        check_val("rst_mid_saldo", saldo_out, 0);

        // Inactivity in PIN
        n_fin = 0;
        insert_card();
        key(4'd1);
        key(4'd2);
`ifdef TIMEOUT_EN
        repeat (15) tick();
        check_val("tmo_pre_estado", estado, 1);
        check_val("tmo_pre_fin", fin, 0);
        tick();
        check_val("tmo_fin", fin, 1);
        check_val("tmo_estado", estado, 0);
        check_val("tmo_saldo", saldo_out, 1000);
`else
        repeat (100) tick();
        check_val("no_tmo_estado", estado, 1);
        check_val("no_tmo_fin", n_fin, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cajero_automatico_param.md
Name: cajero_automatico_param

Overview:
Parametrised successor of the single-transaction ATM controller. It accepts a card, collects a multi-digit PIN with a bounded retry count, then executes one deposit or withdrawal against a loaded balance. It reports the updated balance and signals `fin` at the end of each session. It sits between the card reader/keypad front-end and the account store, and is driven by `tester` in the `test/` benches like its predecessor.

Parameters:
PIN_DIGITS, 4, number of PIN digits per attempt
DIGIT_W, 4, bits per keypad digit
MAX_INTENTOS, 3, wrong-PIN attempts before permanent block (>=1)
MONTO_W, 32, transaction amount width
SALDO_W, 64, balance width (>= MONTO_W)
TIMEOUT_CYC, 1024, inactivity limit in cycles (used only with TIMEOUT_EN)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high
tarjeta_recibida  input  1  card inserted; sampled only in IDLE
pin_correcto  input  PIN_DIGITS*DIGIT_W  expected PIN, first digit in MS digit
digito  input  DIGIT_W  keypad digit
digito_stb  input  1  one-cycle strobe, digito valid
tipo_trans  input  1  0 = deposit, 1 = withdrawal; sampled with monto_stb
monto  input  MONTO_W  transaction amount
monto_stb  input  1  one-cycle strobe, monto/tipo_trans valid
saldo_in  input  SALDO_W  account balance, loaded on card acceptance
saldo_out  output  SALDO_W  current balance register
balance_actualizado  output  1  pulse, saldo_out changed
entregar_dinero  output  1  pulse, withdrawal approved
fondos_insuficientes  output  1  pulse, withdrawal rejected
pin_incorrecto  output  1  pulse, attempt failed
advertencia  output  1  level, exactly one attempt remains
bloqueo  output  1  level, card blocked
fin  output  1  pulse, session ended
estado  output  3  current FSM state encoding (debug)

Behaviour:
- Reset (any state, mid-session included): state IDLE, saldo_out=0, attempt count=0, digit count=0, all pulses 0, advertencia=0, bloqueo=0.
- All outputs are registered. Pulses are high for exactly one cycle.
- IDLE: if tarjeta_recibida=1, load saldo_out<=saldo_in, clear attempt and digit counters, go to PIN. Strobes are ignored in IDLE.
- PIN: each digito_stb shifts digito into the PIN register, MSD first, and increments the digit count. Once the PIN_DIGITS-th digit is captured, go to VERIFICA. monto_stb is ignored.
- VERIFICA (1 cycle, strobes ignored):
  - On match: attempts=0, go to TRANS.
  - On mismatch: attempts+1 and pin_incorrecto pulse. If attempts==MAX_INTENTOS, go to BLOQUEO. Otherwise clear the digit count and go to PIN.
- advertencia=1 while attempts==MAX_INTENTOS-1 and state is PIN. For MAX_INTENTOS=1 it stays 0.
- TRANS: digito_stb is ignored. On monto_stb, latch monto and tipo_trans, then go to DEPOSITO or RETIRO.
- DEPOSITO (1 cycle): saldo_out<=saldo_out+monto, saturating at 2^SALDO_W-1. Pulse balance_actualizado and fin in the same cycle as the update becomes visible, then go to IDLE.
- RETIRO (1 cycle):
  - If monto<=saldo_out: subtract, pulse entregar_dinero, balance_actualizado and fin.
  - Else: balance unchanged, pulse fondos_insuficientes and fin.
  - Go to IDLE.
- Latency: monto_stb at cycle N gives the result pulses visible at cycle N+2.
- BLOQUEO: bloqueo=1 and fin pulses once on entry. The state is terminal until reset, and all inputs are ignored.
- saldo_out holds its value in IDLE after a session, until the next card load.
- Simultaneous digito_stb and monto_stb: only the strobe legal in the current state acts.

Optional Feature:
TIMEOUT_EN
- Defined: in PIN and TRANS, an inactivity counter counts cycles with no legal strobe and is cleared on each legal strobe. When it reaches TIMEOUT_CYC: pulse fin, leave balance unchanged, count no attempt, go to IDLE.
- Undefined: no counter is instantiated, and the FSM waits indefinitely.

Decomposition:
- cajero_pkg: state encoding constants (IDLE=0, PIN=1, VERIFICA=2, TRANS=3, DEPOSITO=4, RETIRO=5, BLOQUEO=6), tipo_trans constants DEPOSITO=0 and RETIRO=1.
- Sub-module cajero_pin_check: digit shift register, digit counter, compare, attempt counter, advertencia. It exports done, match and agotado to the top-level FSM.

Test Plan:
All scenarios use pin_correcto=16'h1234 and saldo_in=1000.
- Reset held 3 cycles, no card -> estado=0, fin=0, all pulses 0, saldo_out=0.
- Card, digits 1,2,3,4, then deposit 500 -> balance_actualizado and fin pulse together, saldo_out=1500, estado back to 0.
- Correct PIN, withdraw 1500 -> fondos_insuficientes and fin, saldo_out=1000. Withdraw 400 instead -> entregar_dinero, saldo_out=600.
- Wrong PINs 1,1,1,1 ×3:
  - pin_incorrecto pulses 3 times.
  - advertencia=1 after the 2nd failure.
  - bloqueo=1 with a single fin pulse.
  - A later tarjeta_recibida is ignored until reset.
- One wrong PIN, then the correct PIN -> pin_incorrecto once, then TRANS is reached and the attempt count is cleared.
- With TIMEOUT_EN and TIMEOUT_CYC=16: card plus 2 digits, then idle 16 cycles -> fin pulse, estado=0, saldo_out=1000. Without the macro: still in PIN after 100 cycles.
